// File: rtl/channel_pkg.sv
// Shared width helpers for the channel bridge and its FIFO.
package channel_pkg;

    // Width needed to index Depth entries (Depth is a power of 2, >= 2).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Width needed to hold an occupancy of 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width of the transfer-per-token counter, 0..every-1.
    function automatic int unsigned tc_w(input int unsigned every);
        return (every <= 2) ? 1 : $clog2(every);
    endfunction

    // Width of the pending-token counter, 0..max_tokens.
    function automatic int unsigned tok_w(input int unsigned max_tokens);
        return (max_tokens <= 1) ? 1 : $clog2(max_tokens + 1);
    endfunction

endpackage

// File: rtl/channel_bridge_if.sv
// Handshake bundle: valid/ack input channel, ready-driven output, dataless sync token.
interface channel_bridge_if #(
    parameter int unsigned N = 8
) ();
    logic         in_v;
    logic [N-1:0] in_d;
    logic         in_a;
    logic         out_r;
    logic         out_v;
    logic [N-1:0] out_d;
    logic         tok_v;
    logic         tok_a;

    modport master (
        output in_v, in_d, out_r, tok_a,
        input  in_a, out_v, out_d, tok_v
    );

    modport slave (
        input  in_v, in_d, out_r, tok_a,
        output in_a, out_v, out_d, tok_v
    );
endinterface

// File: rtl/channel_fifo.sv
// Circular-buffer FIFO; caller only pushes when not full and pops when not empty.
module channel_fifo
    import channel_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned Depth = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [N-1:0] i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [N-1:0] o_head
);
    localparam int unsigned PtrW = ptr_w(Depth);
    localparam int unsigned CntW = cnt_w(Depth);

    logic [N-1:0]    r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    // Pointers wrap naturally because Depth is a power of 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    assign o_full  = (r_count == CntW'(Depth));
    assign o_empty = (r_count == '0);
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: rtl/channel_bridge.sv
// Buffered bridge from a valid/ack channel to a ready-driven channel, emitting a
// sync token every TokenEvery output transfers with bounded pending tokens.
module channel_bridge
    import channel_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned Depth      = 4,
    parameter int unsigned TokenEvery = 4,
    parameter int unsigned MaxTokens  = 7
) (
    input logic              clk,
    input logic              reset,
    channel_bridge_if.slave  bus
);
    localparam int unsigned TcW  = tc_w(TokenEvery);
    localparam int unsigned TokW = tok_w(MaxTokens);

    logic            w_full;
    logic            w_empty;
    logic [N-1:0]    w_head;
    logic            w_push;
    logic            w_pop;
    logic            w_tc_last;
    logic            w_tok_block;
    logic            w_gen;
    logic            w_ack;
    logic [TcW-1:0]  r_tc;
    logic [TcW-1:0]  w_tc_next;
    logic [TokW-1:0] r_pending;
    logic [TokW-1:0] w_pending_next;

    channel_fifo #(
        .N     (N),
        .Depth (Depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (bus.in_d),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Ack is forced low while reset is held, even though the FIFO reads as empty.
    assign bus.in_a = reset & ~w_full;
    assign w_push   = bus.in_v & bus.in_a;

    assign w_tc_last   = (r_tc == TcW'(TokenEvery - 1));
    assign w_tok_block = w_tc_last & (r_pending == TokW'(MaxTokens));

    assign bus.out_v = ~w_empty & bus.out_r & ~w_tok_block;
    assign bus.out_d = w_head;
    assign w_pop     = bus.out_v;

    assign bus.tok_v = (r_pending != '0);
    assign w_gen     = w_pop & w_tc_last;
    assign w_ack     = bus.tok_v & bus.tok_a;

    always_comb begin
        w_tc_next      = r_tc;
        w_pending_next = r_pending;
        if (w_pop) w_tc_next = w_tc_last ? '0 : r_tc + 1'b1;
        if (w_gen && !w_ack)      w_pending_next = r_pending + 1'b1;
        else if (!w_gen && w_ack) w_pending_next = r_pending - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tc      <= '0;
            r_pending <= '0;
        end else begin
            r_tc      <= w_tc_next;
            r_pending <= w_pending_next;
        end
    end
endmodule

// File: tb/tb_channel_bridge.sv
// Directed and random stimulus for channel_bridge checked against a queue-based model.
module tb_channel_bridge;
    localparam int unsigned N          = 8;
    localparam int unsigned Depth      = 4;
    localparam int unsigned TokenEvery = 4;
    localparam int unsigned MaxTokens  = 7;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    channel_bridge_if #(.N(N)) bus ();

    channel_bridge #(
        .N          (N),
        .Depth      (Depth),
        .TokenEvery (TokenEvery),
        .MaxTokens  (MaxTokens)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: word queue, transfers since last token, pending tokens.
    logic [N-1:0] q[$];
    int           tc   = 0;
    int           pend = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [N-1:0] d, input bit r, input bit a);
        bus.in_v  = v;
        bus.in_d  = d;
        bus.out_r = r;
        bus.tok_a = a;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        bit           blocked, exp_a, exp_v, exp_t, push, pop, ack;
        logic [N-1:0] exp_d, d;
        #3;
        blocked = (tc == TokenEvery - 1) && (pend == MaxTokens);
        exp_a   = (q.size() < Depth);
        exp_v   = (q.size() != 0) && (bus.out_r === 1'b1) && !blocked;
        exp_d   = (q.size() != 0) ? q[0] : '0;
        exp_t   = (pend != 0);
        check("in_a",  32'(bus.in_a),  32'(exp_a));
        check("out_v", 32'(bus.out_v), 32'(exp_v));
        check("out_d", 32'(bus.out_d), 32'(exp_d));
        check("tok_v", 32'(bus.tok_v), 32'(exp_t));
        push = (bus.in_v === 1'b1) && exp_a;
        pop  = exp_v;
        ack  = exp_t && (bus.tok_a === 1'b1);
        d    = bus.in_d;
        @(posedge clk);
        if (push) q.push_back(d);
        if (pop) begin
            q.delete(0);
            if (tc == TokenEvery - 1) begin
                tc = 0;
                pend++;
            end else begin
                tc++;
            end
        end
        if (ack) pend--;
        #1;
    endtask

    task automatic run(input int n, input bit v, input bit r, input bit a);
        for (int i = 0; i < n; i++) begin
            drive(v, bus.in_d + 8'h01, r, a);
            step();
        end
    endtask

    // Asynchronous assert away from any edge; outputs must drop at once.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_in_a",  32'(bus.in_a),  32'd0);
        check("rst_out_v", 32'(bus.out_v), 32'd0);
        check("rst_out_d", 32'(bus.out_d), 32'd0);
        check("rst_tok_v", 32'(bus.tok_v), 32'd0);
        q.delete();
        tc   = 0;
        pend = 0;
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, '0, 1'b1, 1'b0);
        #2;
        check("init_in_a",  32'(bus.in_a),  32'd0);
        check("init_out_v", 32'(bus.out_v), 32'd0);
        check("init_tok_v", 32'(bus.tok_v), 32'd0);
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // In-order delivery with one-cycle minimum latency.
        drive(1'b1, 8'h11, 1'b1, 1'b0); step();
        drive(1'b1, 8'h22, 1'b1, 1'b0); step();
        drive(1'b1, 8'h33, 1'b1, 1'b0); step();
        run(3, 1'b0, 1'b1, 1'b0);

        // Fill with the output stalled, fifth attempt refused, then drain.
        bus.in_d = 8'hA0;
        run(5, 1'b1, 1'b0, 1'b0);
        run(5, 1'b0, 1'b1, 1'b0);

        // Prefill two, then sustained push+pop across pointer wrap.
        do_reset();
        run(2, 1'b1, 1'b0, 1'b0);
        run(10, 1'b1, 1'b1, 1'b0);
        check("steady_in_a", 32'(bus.in_a), 32'd1);
        run(3, 1'b0, 1'b1, 1'b0);

        // Accumulate tokens until pop #32 blocks, then release with an ack pulse.
        do_reset();
        run(40, 1'b1, 1'b1, 1'b0);
        check("blk_out_v", 32'(bus.out_v), 32'd0);
        check("blk_tok_v", 32'(bus.tok_v), 32'd1);
        run(1, 1'b1, 1'b1, 1'b1);
        run(3, 1'b1, 1'b1, 1'b0);
        run(4, 1'b0, 1'b1, 1'b1);

        // Token generation coinciding with an ack keeps pending at one.
        do_reset();
        run(5, 1'b1, 1'b1, 1'b0);
        run(3, 1'b1, 1'b1, 1'b0);
        run(1, 1'b1, 1'b1, 1'b1);
        run(1, 1'b0, 1'b0, 1'b0);
        check("gen_ack_tok_v", 32'(bus.tok_v), 32'd1);

        // Reset with three words held and two tokens pending.
        do_reset();
        run(9, 1'b1, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        do_reset();
        run(2, 1'b0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), N'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
